// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and its two-requester arbiter.
// Holds the default widths, the ALU op code constants, the flag bit
// positions inside the packed {C,N,O,Z} flag vector and the arbiter FSM
// state encoding.
package alu_pkg;

    // Default widths; the arbiter must be built with the same widths as the ALU.
    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;
    localparam int FLAG_W_DEF = 4;

    // ALU op codes (semantics are owned by the ALU, the arbiter only forwards them).
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_COMP = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    // Flag bit indices inside {C,N,O,Z}.
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    // Arbiter FSM: one op in flight, each non-idle state lasts one cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way combinational grant with a registered preference pointer.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   req_valid   - request vector, bit i = requester i
//   accept      - high in the cycle the grant is taken; moves the pointer
//   grant       - combinational one-hot (or zero) winner
//
// Build option ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins
// a simultaneous request and the pointer register does not exist.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    // Clock, reset and accept have no function with a fixed priority.
    logic unused_s;
    assign unused_s = &{1'b0, clk, rst, accept};

    // Fixed-priority grant: requester 0 first.
    always_comb begin
        grant = 2'b00;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

`else

    // prefer1_r = 1 means requester 1 wins the next tie (requester 0 won last).
    logic prefer1_r;

    // Round-robin grant: a lone requester wins outright, a tie goes to the preferred one.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prefer1_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer update: after any accept the other requester is preferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer1_r <= 1'b0;
        end else if (accept) begin
            prefer1_r <= grant[0];
        end else begin
            prefer1_r <= prefer1_r;
        end
    end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered-output ALU between two requesters.
// A request is accepted in IDLE, its op/operands are registered onto the
// ALU inputs (ISSUE), the ALU result is captured when valid (WAIT) and
// returned with a one-cycle strobe to the owner (RESP).
// Accept edge to resp_valid = 3 cycles, one op per 4 cycles.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid / req_ready    - per-requester handshake (ready is combinational)
//   req{0,1}_op/_a/_b        - requester op code and operands
//   resp_valid               - one-cycle response strobe to the owner
//   resp_out / resp_flags    - captured ALU result and {C,N,O,Z} flags
//   busy                     - high whenever the FSM is not idle
//   alu_a / alu_b / alu_op   - registered ALU inputs
//   alu_out / alu_flags      - ALU registered result and flags
//
// Build option ALU_ARB_FIXED_PRIO_EN (see rr_arb2): requester 0 always
// wins ties; timing is unchanged.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int FLAG_W = FLAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_out,
    output logic [FLAG_W-1:0] resp_flags,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags
);

    arb_state_e state_r;
    logic       owner_r;
    logic [1:0] grant_s;
    logic       accept_s;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .accept    (accept_s),
        .grant     (grant_s)
    );

    // Handshake: grants are only offered while idle, so ready is zero otherwise.
    always_comb begin
        req_ready = 2'b00;
        accept_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            req_ready = grant_s;
            accept_s  = (grant_s != 2'b00);
        end else begin
            req_ready = 2'b00;
            accept_s  = 1'b0;
        end
    end

    // Operation sequencer: accept, issue, wait out the ALU register, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 2'b00;
            resp_out   <= '0;
            resp_flags <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r <= grant_s[1];
                        alu_op  <= grant_s[1] ? req1_op : req0_op;
                        alu_a   <= grant_s[1] ? req1_a  : req0_a;
                        alu_b   <= grant_s[1] ? req1_b  : req0_b;
                        busy    <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // ALU samples alu_a/alu_b/alu_op at the end of this cycle.
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    resp_out   <= alu_out;
                    resp_flags <= alu_flags;
                    resp_valid <= {owner_r, ~owner_r};
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 2'b00;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    resp_valid <= 2'b00;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural
// registered ALU. A transaction-level model (cycle arithmetic plus a queue
// of expected responses) predicts every output each cycle; directed
// sequences add checks against fixed expected constants.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
    logic [1:0] resp_valid;
    logic [7:0] resp_out;
    logic [3:0] resp_flags;
    logic       busy;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic [3:0] alu_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_out(resp_out), .resp_flags(resp_flags),
        .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    // Reference ALU: returns {C,N,O,Z, result}.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, o;
        w = 9'd0; r = 8'd0; c = 1'b0; o = 1'b0;
        case (op)
            OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
            OP_SUB:  begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_NOT:  r = ~a;
            OP_COMP: r = (a == b) ? 8'h01 : 8'h00;
            OP_SHR:  begin r = a >> 1; c = a[0]; end
            default: begin r = a << 1; c = a[7]; end
        endcase
        return {c, r[7], o, (r == 8'h00), r};
    endfunction

    // Registered ALU stand-in.
    always @(posedge clk) begin
        {alu_flags, alu_out} <= alu_ref(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level model state.
    typedef struct {
        int         due;
        logic [1:0] strobe;
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;
    exp_t       pend[$];
    int         cyc = 0;
    int         free_at = 0;
    bit         pref1 = 1'b0;
    logic [1:0] last_g = 2'b00;
    logic [7:0] hold_r = 8'd0, ea = 8'd0, eb = 8'd0;
    logic [3:0] hold_f = 4'd0;
    logic [2:0] eop = 3'd0;

    // One clock cycle: called just after a negedge with this cycle's inputs applied.
    task automatic step_cycle();
        logic [1:0]  g, erv;
        logic [11:0] fr;
        logic        own;
        #1;
        g = 2'b00;
        if (cyc >= free_at) begin
            case (req_valid)
                2'b01: g = 2'b01;
                2'b10: g = 2'b10;
                2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    g = 2'b01;
`else
                    g = pref1 ? 2'b10 : 2'b01;
`endif
                end
                default: g = 2'b00;
            endcase
        end
        erv = 2'b00;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            erv    = pend[0].strobe;
            hold_r = pend[0].r;
            hold_f = pend[0].f;
            void'(pend.pop_front());
        end
        chk("req_ready",  16'(req_ready),  16'(g));
        chk("resp_valid", 16'(resp_valid), 16'(erv));
        chk("resp_out",   16'(resp_out),   16'(hold_r));
        chk("resp_flags", 16'(resp_flags), 16'(hold_f));
        chk("busy",       16'(busy),       16'(cyc < free_at));
        chk("alu_a",      16'(alu_a),      16'(ea));
        chk("alu_b",      16'(alu_b),      16'(eb));
        chk("alu_op",     16'(alu_op),     16'(eop));
        if (rst) begin
            pend.delete();
            free_at = cyc + 1;
            pref1 = 1'b0;
            hold_r = 8'd0; hold_f = 4'd0;
            ea = 8'd0; eb = 8'd0; eop = 3'd0;
            last_g = 2'b00;
        end else begin
            last_g = g;
            if (g != 2'b00) begin
                own = g[1];
                eop = own ? req1_op : req0_op;
                ea  = own ? req1_a  : req0_a;
                eb  = own ? req1_b  : req0_b;
                fr  = alu_ref(eop, ea, eb);
                pend.push_back('{cyc + 3, g, fr[7:0], fr[11:8]});
                free_at = cyc + 4;
                pref1 = ~own;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (i == 0) begin req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_op = op; req1_a = a; req1_b = b; end
    endtask

    logic [1:0] cv;
    logic [2:0] cop [2];
    logic [7:0] ca [2];
    logic [7:0] cb [2];

    initial begin
        // Initial reset and reset-state checks.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 16'(req_ready), 16'd0);
        chk("rst_resp_valid", 16'(resp_valid), 16'd0);
        chk("rst_resp_out", 16'(resp_out), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_alu", 16'({alu_a, alu_b} | 16'(alu_op)), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single add from requester 0.
        set_req(0, OP_ADD, 8'h03, 8'h11); req_valid = 2'b01;
        #1 chk("add_ready", 16'(req_ready), 16'h0001);
        step_cycle();
        req_valid = 2'b00;
        repeat (2) step_cycle();
        chk("add_rv", 16'(resp_valid), 16'h0001);
        chk("add_out", 16'(resp_out), 16'h0014);
        chk("add_flags", 16'(resp_flags), 16'h0000);
        step_cycle();

        // Subtract with borrow from requester 1.
        set_req(1, OP_SUB, 8'h01, 8'h02); req_valid = 2'b10;
        step_cycle();
        req_valid = 2'b00;
        repeat (2) step_cycle();
        chk("sub_rv", 16'(resp_valid), 16'h0002);
        chk("sub_out", 16'(resp_out), 16'h00FF);
        chk("sub_flags", 16'(resp_flags), 16'h000C);
        step_cycle();

        // Contention: both requesters continuously valid.
        set_req(0, OP_ADD, 8'h40, 8'hC0);
        set_req(1, OP_COMP, 8'h53, 8'h53);
        req_valid = 2'b11;
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0) begin
                #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                chk("cont_grant", 16'(req_ready), 16'h0001);
`else
                chk("cont_grant", 16'(req_ready), ((k / 4) % 2 == 0) ? 16'h0001 : 16'h0002);
`endif
            end
            step_cycle();
            if (k == 2) begin
                chk("cont_out0", 16'(resp_out), 16'h0000);
                chk("cont_flags0", 16'(resp_flags), 16'h0009);
            end
            if (k == 6) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                chk("cont_out1", 16'(resp_out), 16'h0000);
`else
                chk("cont_out1", 16'(resp_out), 16'h0001);
                chk("cont_flags1", 16'(resp_flags), 16'h0000);
`endif
            end
        end
        req_valid = 2'b00;
        step_cycle();

        // Back-pressure: requester 1 arrives while requester 0 is in WAIT.
        set_req(0, OP_AND, 8'hF0, 8'h3C); req_valid = 2'b01;
        step_cycle();
        req_valid = 2'b00;
        step_cycle();
        set_req(1, OP_SUB, 8'h01, 8'h02); req_valid = 2'b10;
        #1 chk("bp_wait_ready", 16'(req_ready), 16'h0000);
        step_cycle();
        #1 chk("bp_resp_ready", 16'(req_ready), 16'h0000);
        step_cycle();
        #1 chk("bp_idle_ready", 16'(req_ready), 16'h0002);
        step_cycle();
        req_valid = 2'b00;
        chk("bp_alu_a", 16'(alu_a), 16'h0001);
        chk("bp_alu_b", 16'(alu_b), 16'h0002);
        chk("bp_alu_op", 16'(alu_op), 16'(OP_SUB));
        repeat (3) step_cycle();

        // Reset during WAIT.
        set_req(0, OP_ADD, 8'h22, 8'h33); req_valid = 2'b01;
        step_cycle();
        req_valid = 2'b00;
        step_cycle();
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        chk("rmid_rv", 16'(resp_valid), 16'h0000);
        chk("rmid_busy", 16'(busy), 16'h0000);
        chk("rmid_alu", 16'({alu_a, alu_b} | 16'(alu_op)), 16'h0000);
        set_req(0, OP_SHL, 8'h53, 8'h00); req_valid = 2'b01;
        step_cycle();
        req_valid = 2'b00;
        repeat (2) step_cycle();
        chk("shl_rv", 16'(resp_valid), 16'h0001);
        chk("shl_out", 16'(resp_out), 16'h00A6);
        step_cycle();

        // Idle for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("idle_ready", 16'(req_ready), 16'h0000);
            chk("idle_rv", 16'(resp_valid), 16'h0000);
            chk("idle_busy", 16'(busy), 16'h0000);
            step_cycle();
        end

        // Randomised traffic with withdrawals and occasional resets.
        cv = 2'b00;
        for (int i = 0; i < 2; i++) begin cop[i] = 3'd0; ca[i] = 8'd0; cb[i] = 8'd0; end
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (cv[i] && !last_g[i]) begin
                    if ($urandom_range(7) == 0) cv[i] = 1'b0;
                end else begin
                    cv[i]  = ($urandom_range(3) != 0);
                    cop[i] = 3'($urandom_range(7));
                    ca[i]  = 8'($urandom_range(255));
                    cb[i]  = 8'($urandom_range(255));
                end
            end
            set_req(0, cop[0], ca[0], cb[0]);
            set_req(1, cop[1], ca[1], cb[1]);
            req_valid = cv;
            rst = ($urandom_range(63) == 0);
            step_cycle();
        end
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (6) step_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
